// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the mem_bus_master slice.
//   READ / WRITE    : memory_rw encodings
//   SZ_BYTE/HALF/WORD : req_size codes (2'b11 is handled as a word)
//   state_e         : bus master FSM states
package mem_bus_pkg;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: combinational byte-lane logic for a big-endian word memory
// (byte offset k lives in rd_word[31-8k -: 8]).
//   rd_word     in  32  word captured from memory
//   size        in  2   request size code
//   offset      in  2   byte offset within the word (addr[1:0])
//   is_unsigned in  1   zero-extend loads when 1, sign-extend when 0
//   wdata       in  32  right-aligned store data
//   load_data   out 32  extracted and extended load value
//   store_word  out 32  word to write: rd_word with target lane(s) replaced
//                       for sub-word stores, wdata for word stores
module mem_lane_unit
   import mem_bus_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte   = '0;
      load_data  = rd_word;
      store_word = wdata;

      case (offset)
         2'd0:    sel_byte = rd_word[31:24];
         2'd1:    sel_byte = rd_word[23:16];
         2'd2:    sel_byte = rd_word[15:8];
         default: sel_byte = rd_word[7:0];
      endcase
      // Half lanes are chosen by offset[1] only; offset[0] is don't-care here.
      sel_half = offset[1] ? rd_word[15:0] : rd_word[31:16];

      case (size)
         SZ_BYTE: begin
            load_data  = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
            store_word = rd_word;
            case (offset)
               2'd0:    store_word[31:24] = wdata[7:0];
               2'd1:    store_word[23:16] = wdata[7:0];
               2'd2:    store_word[15:8]  = wdata[7:0];
               default: store_word[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            load_data  = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
            store_word = rd_word;
            if (offset[1]) store_word[15:0]  = wdata[15:0];
            else           store_word[31:16] = wdata[15:0];
         end
         default: begin
            load_data  = rd_word;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: MEM-stage bus initiator for a word-wide, byte-addressed,
// big-endian data memory. One load/store per request; sub-word stores are
// done as read-modify-write because the memory always writes 4 bytes.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned half/word requests
// complete immediately with rsp_err=1 and no bus activity).
// Ports:
//   clk, rst_         clock; synchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata   request fields, latched on accept
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata/rsp_err load data / misalignment flag, valid with rsp_valid
//   memory_addr/as_/rw/wr_data/rd_data   memory bus
module mem_bus_master
   import mem_bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst_,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [29:0] memory_addr,
   output logic        memory_as_,
   output logic        memory_rw,
   output logic [31:0] memory_wr_data,
   input  logic [31:0] memory_rd_data
);

   state_e      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdword_q, rdword_d;
   logic        err_q, err_d;

   logic        misalign;
   logic [1:0]  norm_size;
   logic [31:0] load_data;
   logic [31:0] store_word;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:30];
   assign norm_size      = (req_size == 2'b11) ? SZ_WORD : req_size;

   always_comb begin
      misalign = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if (norm_size == SZ_HALF && req_addr[0])              misalign = 1'b1;
      if (norm_size == SZ_WORD && req_addr[1:0] != 2'b00)   misalign = 1'b1;
`endif
   end

   mem_lane_unit u_lane (
      .rd_word     (rdword_q),
      .size        (size_q),
      .offset      (addr_q[1:0]),
      .is_unsigned (uns_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      we_d     = we_q;
      uns_d    = uns_q;
      wdata_d  = wdata_q;
      rdword_d = rdword_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr[29:0];
               size_d  = norm_size;
               we_d    = req_we;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               err_d   = misalign;
               if (misalign)                          state_d = S_RESP;
               else if (req_we && norm_size == SZ_WORD) state_d = S_WRITE;
               else                                   state_d = S_READ;
            end
         end
         S_READ: begin
            rdword_d = memory_rd_data;
            state_d  = we_q ? S_WRITE : S_RESP;
         end
         S_WRITE: state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         size_q   <= SZ_WORD;
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         wdata_q  <= '0;
         rdword_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         we_q     <= we_d;
         uns_q    <= uns_d;
         wdata_q  <= wdata_d;
         rdword_q <= rdword_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      req_ready      = (state_q == S_IDLE);
      rsp_valid      = (state_q == S_RESP);
      rsp_err        = rsp_valid & err_q;
      rsp_rdata      = (rsp_valid && !we_q && !err_q) ? load_data : '0;
      memory_addr    = {addr_q[29:2], 2'b00};
      memory_as_     = 1'b1;
      memory_rw      = READ;
      memory_wr_data = '0;
      if (state_q == S_READ) begin
         memory_as_ = 1'b0;
      end else if (state_q == S_WRITE) begin
         memory_as_     = 1'b0;
         memory_rw      = WRITE;
         memory_wr_data = store_word;
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed self-checking bench for mem_bus_master with a
// big-endian byte memory model. Build with or without MEM_ALIGN_CHECK_EN.
module tb_mem_bus_master;

   logic        clk = 1'b0;
   logic        rst_;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [29:0] memory_addr;
   logic        memory_as_, memory_rw;
   logic [31:0] memory_wr_data, memory_rd_data;

   int total = 0;
   int bad   = 0;
   int rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
   logic [31:0] last_wr = '0;

   logic [7:0] mem [0:1023];
   logic [9:0] wbase;

   always #5 clk = ~clk;

   mem_bus_master dut (
      .clk            (clk),
      .rst_           (rst_),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .memory_addr    (memory_addr),
      .memory_as_     (memory_as_),
      .memory_rw      (memory_rw),
      .memory_wr_data (memory_wr_data),
      .memory_rd_data (memory_rd_data)
   );

   assign wbase = {memory_addr[9:2], 2'b00};

   always_comb begin
      if (!memory_as_ && memory_rw)
         memory_rd_data = {mem[wbase], mem[wbase | 10'd1], mem[wbase | 10'd2], mem[wbase | 10'd3]};
      else
         memory_rd_data = 32'hDEADBEEF;
   end

   always @(posedge clk) begin
      if (!memory_as_ && !memory_rw) begin
         mem[wbase]         <= memory_wr_data[31:24];
         mem[wbase | 10'd1] <= memory_wr_data[23:16];
         mem[wbase | 10'd2] <= memory_wr_data[15:8];
         mem[wbase | 10'd3] <= memory_wr_data[7:0];
         wr_cnt  <= wr_cnt + 1;
         last_wr <= memory_wr_data;
      end
      if (!memory_as_ && memory_rw) rd_cnt <= rd_cnt + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE, wait (bounded) for rsp_valid, then check the
   // response, latency, bus activity and the return to IDLE.
   task automatic xact(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input int exp_lat, input logic exp_err,
                       input int exp_rd, input int exp_wr);
      int lat;
      int r0, w0;
      r0 = rd_cnt;
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         tick();
         lat++;
      end
      if (!rsp_valid) lat = 99;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_data"}, rsp_rdata, exp_data);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      tick();
      chk({tag, "_reads"}, rd_cnt - r0, exp_rd);
      chk({tag, "_writes"}, wr_cnt - w0, exp_wr);
      chk({tag, "_idle_rdy"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_idle_rdata"}, rsp_rdata, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0, r0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h100] = 8'h11;
      mem[10'h101] = 8'h22;
      mem[10'h102] = 8'h83;
      mem[10'h103] = 8'h44;

      rst_ = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      tick();
      tick();
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_as", {31'd0, memory_as_}, 32'd1);
      chk("rst_rw", {31'd0, memory_rw}, 32'd1);
      chk("rst_addr", {2'b00, memory_addr}, 32'd0);
      chk("rst_wdata", memory_wr_data, 32'd0);
      rst_ = 1'b1;
      tick();

      // Loads on preloaded data 11 22 83 44.
      xact("ld_word",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11228344, 2, 1'b0, 1, 0);
      xact("ld_sb",    1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'hFFFFFF83, 2, 1'b0, 1, 0);
      xact("ld_ub",    1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h00000083, 2, 1'b0, 1, 0);
      xact("ld_sh",    1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF8344, 2, 1'b0, 1, 0);
      xact("ld_sb0",   1'b0, 2'b00, 1'b0, 32'hC000_0100, 32'h0, 32'h00000011, 2, 1'b0, 1, 0);

      // Sub-word and word stores.
      xact("st_byte",  1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFFAB, 32'h0, 3, 1'b0, 1, 1);
      chk("st_byte_wdata", last_wr, 32'h11AB8344);
      xact("rl_byte",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11AB8344, 2, 1'b0, 1, 0);
      xact("st_half",  1'b1, 2'b01, 1'b0, 32'h102, 32'h1234BEEF, 32'h0, 3, 1'b0, 1, 1);
      chk("st_half_wdata", last_wr, 32'h11ABBEEF);
      xact("ld_sb3",   1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFFEF, 2, 1'b0, 1, 0);
      xact("ld_uh0",   1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h000011AB, 2, 1'b0, 1, 0);
      xact("st_word",  1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 2, 1'b0, 0, 1);
      chk("st_word_wdata", last_wr, 32'hCAFEF00D);
      xact("ld_sh4",   1'b0, 2'b01, 1'b0, 32'h104, 32'h0, 32'hFFFFCAFE, 2, 1'b0, 1, 0);
      xact("ld_sz3",   1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 2, 1'b0, 1, 0);

      // Back-to-back: req_valid held high across two loads.
      a0 = acc_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h100;
      tick();
      chk("b2b_rdy_read", {31'd0, req_ready}, 32'd0);
      tick();
      chk("b2b_rdy_resp", {31'd0, req_ready}, 32'd0);
      chk("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_data1", rsp_rdata, 32'h11ABBEEF);
      tick();
      chk("b2b_rdy_idle", {31'd0, req_ready}, 32'd1);
      chk("b2b_acc1", acc_cnt - a0, 32'd1);
      tick();
      chk("b2b_acc2", acc_cnt - a0, 32'd2);
      chk("b2b_rdy_read2", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      tick();
      chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);
      tick();

      // Reset during the WRITE cycle of a word store.
      r0 = rsp_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h108;
      req_wdata = 32'h12345678;
      tick();
      req_valid = 1'b0;
      chk("rw_in_write_as", {31'd0, memory_as_}, 32'd0);
      chk("rw_in_write_rw", {31'd0, memory_rw}, 32'd0);
      rst_ = 1'b0;
      tick();
      rst_ = 1'b1;
      chk("rw_as", {31'd0, memory_as_}, 32'd1);
      chk("rw_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rw_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("rw_rsp_after", {31'd0, rsp_valid}, 32'd0);
      chk("rw_rsp_count", rsp_cnt - r0, 32'd0);

      // Misaligned word load.
`ifdef MEM_ALIGN_CHECK_EN
      xact("mis_word", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1, 1'b1, 0, 0);
      xact("mis_half", 1'b1, 2'b01, 1'b0, 32'h101, 32'h7777, 32'h0, 1, 1'b1, 0, 0);
`else
      xact("mis_word", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h11ABBEEF, 2, 1'b0, 1, 0);
      xact("mis_half", 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'h000011AB, 2, 1'b0, 1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
